// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Shares one single-ported, synchronous-read memory between an
// instruction-fetch port and a data load/store port. Each access takes two
// cycles. In the issue cycle (IDLE), the winner drives the memory strobe
// combinationally. In the response cycle (RESP_IF / RESP_D), the matching
// valid pulses and read data is passed straight through from mem_rdata_i.
//
// Data normally wins over fetch. A saturating starvation counter forces a
// fetch grant once STARVE_MAX data accesses in a row have overtaken a waiting
// fetch.
//
// Ports
//   clk_i, rst_i                  clock, synchronous active-high reset
//   if_req_i, if_addr_i           fetch request (held until if_valid_o), byte address
//   if_rdata_o, if_valid_o        fetched word, one-cycle completion pulse
//   d_rd_i, d_wr_i                data read / write request (held until d_valid_o)
//   d_addr_i, d_wdata_i           data byte address, store data
//   d_rdata_o, d_valid_o          load data, one-cycle completion pulse
//   mem_en_o, mem_we_o            memory strobe, write enable
//   mem_addr_o, mem_wdata_o       word address, write data
//   mem_rdata_i                   memory read data, one cycle after mem_en_o
//   if_stall_o, d_stall_o         requester stalls
//   err_o                         sticky: d_rd_i and d_wr_i seen high together
// -----------------------------------------------------------------------------
module mem_arbiter #(
    parameter int ADDR_W     = 12,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic [31:0]       if_rdata_o,
    output logic              if_valid_o,
    input  logic              d_rd_i,
    input  logic              d_wr_i,
    input  logic [ADDR_W-1:0] d_addr_i,
    input  logic [31:0]       d_wdata_i,
    output logic [31:0]       d_rdata_o,
    output logic              d_valid_o,
    output logic              mem_en_o,
    output logic              mem_we_o,
    output logic [ADDR_W-3:0] mem_addr_o,
    output logic [31:0]       mem_wdata_o,
    input  logic [31:0]       mem_rdata_i,
    output logic              if_stall_o,
    output logic              d_stall_o,
    output logic              err_o
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RESP_IF = 2'd1,
        RESP_D  = 2'd2
    } state_e;

    state_e     state_q;
    logic [2:0] starve_q;
    logic [2:0] starve_d;
    logic       err_q;

    logic d_req;
    logic issue;
    logic fetch_wins;

    // Byte-offset bits select nothing in a word-wide memory.
    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^{if_addr_i[1:0], d_addr_i[1:0]};

    assign d_req = d_rd_i | d_wr_i;

    // Accesses are only issued from IDLE. Reset suppresses the strobe at once,
    // not only from the next edge.
    assign issue = (state_q == IDLE) && (if_req_i || d_req) && !rst_i;

    // Fetch wins when it is alone or when it has been overtaken STARVE_MAX times.
    assign fetch_wins = if_req_i && (!d_req || (starve_q == 3'(STARVE_MAX)));

    // Starvation counter: cleared on a fetch grant. It counts data grants that
    // overtake a waiting fetch, and saturates instead of wrapping.
    always_comb begin
        starve_d = starve_q;
        if (issue) begin
            if (fetch_wins) begin
                starve_d = 3'd0;
            end else if (if_req_i && (starve_q != 3'd7)) begin
                starve_d = starve_q + 3'd1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            starve_q <= 3'd0;
            err_q    <= 1'b0;
        end else begin
            starve_q <= starve_d;
            err_q    <= err_q | (d_rd_i & d_wr_i);
            case (state_q)
                IDLE: begin
                    if (issue) begin
                        state_q <= fetch_wins ? RESP_IF : RESP_D;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Memory port: driven from the winner in the issue cycle, otherwise zero.
    // A read+write collision is treated as a write.
    assign mem_en_o    = issue;
    assign mem_we_o    = issue && !fetch_wins && d_wr_i;
    assign mem_addr_o  = !issue     ? '0 :
                         fetch_wins ? if_addr_i[ADDR_W-1:2] : d_addr_i[ADDR_W-1:2];
    assign mem_wdata_o = mem_we_o ? d_wdata_i : 32'd0;

    // Responses follow the state register. Reset gating discards a pending
    // response in the cycle rst_i is raised.
    assign if_valid_o = (state_q == RESP_IF) && !rst_i;
    assign d_valid_o  = (state_q == RESP_D)  && !rst_i;
    assign if_rdata_o = if_valid_o ? mem_rdata_i : 32'd0;
    assign d_rdata_o  = d_valid_o  ? mem_rdata_i : 32'd0;

    assign if_stall_o = if_req_i & ~if_valid_o;
    assign d_stall_o  = d_req & ~d_valid_o;
    assign err_o      = err_q;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 12, byte-address width of the shared memory port.
REQ-002 Parameter STARVE_MAX, default 4, range 1..7; consecutive data wins allowed while a fetch waits.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 if_req  input  1  instruction-fetch request, held until if_valid.
REQ-006 if_addr  input  ADDR_W  fetch byte address, stable while if_req high.
REQ-007 if_rdata  output  32  fetched instruction, meaningful only when if_valid=1.
REQ-008 if_valid  output  1  one-cycle pulse, fetch complete.
REQ-009 d_rd  input  1  data read request, held until d_valid.
REQ-010 d_wr  input  1  data write request, held until d_valid.
REQ-011 d_addr  input  ADDR_W  data byte address.
REQ-012 d_wdata  input  32  store data.
REQ-013 d_rdata  output  32  load data, meaningful only when d_valid=1 after a read.
REQ-014 d_valid  output  1  one-cycle pulse, data access complete (read or write).
REQ-015 mem_en  output  1  memory access strobe.
REQ-016 mem_we  output  1  memory write enable.
REQ-017 mem_addr  output  ADDR_W-2  word address, winner address bits [ADDR_W-1:2].
REQ-018 mem_wdata  output  32  write data to memory.
REQ-019 mem_rdata  input  32  memory read data, valid the cycle after mem_en (synchronous read).
REQ-020 if_stall  output  1  if_req & ~if_valid.
REQ-021 d_stall  output  1  (d_rd|d_wr) & ~d_valid.
REQ-022 err  output  1  sticky flag, d_rd and d_wr seen high together.

Function
REQ-023 FSM states IDLE, RESP_IF, RESP_D; only IDLE issues accesses.
REQ-024 In IDLE with any request: mem_en=1 same cycle (combinational); mem_addr/mem_we/mem_wdata from winner.
REQ-025 IDLE -> RESP_IF if fetch wins, IDLE -> RESP_D if data wins, IDLE -> IDLE if no request.
REQ-026 RESP_IF and RESP_D always return to IDLE next cycle; no access issued in RESP states (mem_en=0).
REQ-027 RESP_IF: if_valid=1, if_rdata=mem_rdata; RESP_D: d_valid=1, d_rdata=mem_rdata (don't-care after writes).
REQ-028 Latency: request seen in IDLE at cycle N -> valid at cycle N+1; throughput one access per 2 cycles.
REQ-029 Priority: data wins over fetch unless starve_cnt==STARVE_MAX, then fetch wins.
REQ-030 starve_cnt (3 bit): +1 when data wins with if_req high; cleared to 0 when fetch wins; never wraps.
REQ-031 d_rd & d_wr both high in IDLE: treated as write (mem_we=1), err set to 1 until reset.
REQ-032 Request inputs sampled only in IDLE; deassertion during a RESP state does not cancel the access.
REQ-033 if_stall/d_stall combinational; the requester receiving valid sees stall=0 that cycle.
REQ-034 Write: mem_we=1, mem_wdata=d_wdata in the issue cycle; d_valid pulses next cycle as write ack.

Reset
REQ-035 rst high at edge: state=IDLE, starve_cnt=0, err=0.
REQ-036 While rst high: mem_en=0, mem_we=0, if_valid=0, d_valid=0; mem_addr, mem_wdata, rdata outputs 0.
REQ-037 rst in RESP state: pending response discarded, no valid pulse; issued writes are not undone.

Verification
REQ-038 Fetch only: if_req=1, if_addr=0x010, mem_rdata=0x00500093 next cycle -> mem_en=1, mem_addr=0x004, then if_valid=1, if_rdata=0x00500093.
REQ-039 Contention: if_req=1 and d_rd=1 (d_addr=0x020) same IDLE cycle -> data issued first (mem_addr=0x008), d_valid at N+1, fetch issued N+2, if_valid N+3.
REQ-040 Starvation: if_req held high, d_rd re-asserted every IDLE, STARVE_MAX=4 -> four data accesses, fifth grant to fetch, starve_cnt back to 0.
REQ-041 Write: d_wr=1, d_addr=0x0FC, d_wdata=0xDEADBEEF -> mem_en=1, mem_we=1, mem_addr=0x03F, mem_wdata=0xDEADBEEF; d_valid=1 next cycle.
REQ-042 Illegal: d_rd=1 and d_wr=1 -> write issued, err=1 held until rst.
REQ-043 Reset mid-op: rst=1 in RESP_IF -> no if_valid pulse, state IDLE, mem_en=0 while rst high; if_req still high after rst falls -> re-fetched normally.
